multibuffer_stream_queue: RTL and testbench

Width-converting FIFO: wide words in, narrow slices out, full valid/ready backpressure on both sides. Successor to the multibuffer queue. Read-side abort/recovery is replaced by a prefetch skid buffer sized to RAM latency. Adds a programmable almost-full margin, occupancy output, synchronous flush and a sticky overflow flag. Sits between a wide DMA/ingress stage and a narrow packet consumer.

---
 rtl/multibuffer_stream_queue_pkg.sv | 49 ++++
 rtl/multibuffer_stream_queue_if.sv | 19 +
 rtl/multibuffer_stream_queue_sdp_ram.sv | 32 +++
 rtl/multibuffer_stream_queue.sv | 204 ++++++++++++++++++++
 tb/tb_multibuffer_stream_queue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multibuffer_stream_queue_pkg.sv
// Shared widths and helpers for the wide-in / narrow-out stream queue.
package mbq_pkg;

  // Upper bound on the write word width accepted by slice_sel.
  localparam int MAX_IN_W = 1024;

  // Number of narrow slices per wide word.
  function automatic int ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Bits needed to index a slice inside a wide entry (0 when one slice per word).
  function automatic int sidx_w(input int in_w, input int out_w);
    return $clog2(in_w / out_w);
  endfunction

  // Slice index field width as carried in flops (never zero-width).
  function automatic int sel_w(input int in_w, input int out_w);
    return (sidx_w(in_w, out_w) == 0) ? 1 : sidx_w(in_w, out_w);
  endfunction

  // Write pointer carries one wrap bit above the RAM address.
  function automatic int wptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // Read pointer: wrap bit, entry address, slice index.
  function automatic int rptr_w(input int depth_log2, input int in_w, input int out_w);
    return depth_log2 + sidx_w(in_w, out_w) + 1;
  endfunction

  // Level counts 0..2^depth_log2 entries.
  function automatic int level_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // The RAM supports 1 or 2 cycles of read latency; anything else falls back to 2.
  function automatic int legal_latency(input int lat);
    return (lat == 1 || lat == 2) ? lat : 2;
  endfunction

  // Little-endian slice select: slice idx sits in the LSBs of the result.
  function automatic logic [MAX_IN_W-1:0] slice_sel(input logic [MAX_IN_W-1:0] word,
                                                    input int unsigned       idx,
                                                    input int unsigned       out_w);
    return word >> (idx * out_w);
  endfunction

endpackage

// File: rtl/multibuffer_stream_queue_if.sv
// Write and read handshake bundle for the stream queue.
interface multibuffer_stream_queue_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [IN_WIDTH-1:0]  wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [OUT_WIDTH-1:0] rd_data;

  // Producer/consumer side.
  modport master (output wr_valid, wr_data, rd_ready,
                  input  wr_ready, rd_valid, rd_data);
  // Queue side.
  modport slave  (input  wr_valid, wr_data, rd_ready,
                  output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/multibuffer_stream_queue_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port,
// optional output register for two-cycle read latency.
module sdp_ram #(
  parameter int WIDTH       = 128,
  parameter int ADDR_W      = 10,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [1 << ADDR_W];
  logic [WIDTH-1:0] rd_q;

  // Storage write and first read stage; address sampled every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  if (RAM_LATENCY == 2) begin : g_oreg
    logic [WIDTH-1:0] out_q;
    // Output register stage.
    always_ff @(posedge clk) out_q <= rd_q;
    assign rdata = out_q;
  end else begin : g_noreg
    assign rdata = rd_q;
  end
endmodule

// File: rtl/multibuffer_stream_queue.sv
// Width-converting FIFO: wide words written, narrow little-endian slices read.
// Reads are prefetched from the RAM into a skid buffer sized to cover the RAM
// latency, so the consumer sees one slice per cycle with full backpressure.
module multibuffer_stream_queue
  import mbq_pkg::*;
#(
  parameter int IN_WIDTH     = 128,
  parameter int OUT_WIDTH    = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int AFULL_MARGIN = 16,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  multibuffer_stream_queue_if.slave bus,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   overflow
);
  localparam int R       = ratio(IN_WIDTH, OUT_WIDTH);
  localparam int SIDX_W  = sidx_w(IN_WIDTH, OUT_WIDTH);
  localparam int SEL_W   = sel_w(IN_WIDTH, OUT_WIDTH);
  localparam int WP_W    = wptr_w(DEPTH_LOG2);
  localparam int RP_W    = rptr_w(DEPTH_LOG2, IN_WIDTH, OUT_WIDTH);
  localparam int LVL_W   = level_w(DEPTH_LOG2);
  localparam int LAT     = legal_latency(RAM_LATENCY);
  localparam int SKID_N  = LAT + 1;
  localparam int SKID_AW = $clog2(SKID_N);
  localparam int SKID_CW = $clog2(SKID_N + 1);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(DEPTH - AFULL_MARGIN);
  localparam logic [SEL_W-1:0] LAST_SIDX = SEL_W'(R - 1);

  logic [WP_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RP_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WP_W-1:0]  rd_entry_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;

  logic [LAT-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][SEL_W-1:0] sidx_pipe_q, sidx_pipe_d;

  logic [OUT_WIDTH-1:0] skid_q [SKID_N];
  logic [OUT_WIDTH-1:0] skid_d [SKID_N];
  logic [SKID_AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [SKID_CW-1:0]   cnt_q, cnt_d;

  logic                 wr_ready, rd_valid;
  logic                 wr_acc, issue, push, pop, last_slice;
  logic [SEL_W-1:0]     cur_sidx;
  logic [IN_WIDTH-1:0]  ram_rdata;
  logic [OUT_WIDTH-1:0] ram_slice;
  int unsigned          occ;

  function automatic logic [SKID_AW-1:0] skid_inc(input logic [SKID_AW-1:0] p);
    return (p == SKID_AW'(SKID_N - 1)) ? '0 : p + SKID_AW'(1);
  endfunction

  if (SIDX_W > 0) begin : g_sidx
    assign cur_sidx = SEL_W'(rd_ptr_q[SIDX_W-1:0]);
  end else begin : g_nosidx
    assign cur_sidx = '0;
  end

  assign last_slice   = (cur_sidx == LAST_SIDX);
  assign wr_ready     = !full_q && !flush;
  assign rd_valid     = (cnt_q != '0);
  assign wr_acc       = bus.wr_valid && wr_ready;
  assign pop          = rd_valid && bus.rd_ready;
  assign push         = vld_pipe_q[LAT-1] && !flush;
  assign ram_slice    = OUT_WIDTH'(slice_sel(MAX_IN_W'(ram_rdata), 32'(sidx_pipe_q[LAT-1]),
                                             OUT_WIDTH));

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? skid_q[head_q] : '0;
  assign level        = level_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;

  sdp_ram #(
    .WIDTH      (IN_WIDTH),
    .ADDR_W     (DEPTH_LOG2),
    .RAM_LATENCY(LAT)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata(bus.wr_data),
    .raddr(rd_ptr_q[RP_W-2:SIDX_W]),
    .rdata(ram_rdata)
  );

  // Issue when a slice is pending and a skid slot is guaranteed; a pop in this
  // cycle frees a slot, which keeps a streaming consumer bubble-free.
  always_comb begin
    occ = 32'(cnt_q);
    for (int i = 0; i < LAT; i++) occ = occ + 32'(vld_pipe_q[i]);
    issue = !flush && (level_q != '0) && ((occ - 32'(pop)) < 32'(SKID_N));
  end

  // Pointer advance and registered status flags derived from next pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + WP_W'(1);
      if (issue)  rd_ptr_d = rd_ptr_q + RP_W'(1);
    end
    rd_entry_d = rd_ptr_d[RP_W-1:SIDX_W];
    level_d    = wr_ptr_d - rd_entry_d;
    full_d     = (wr_ptr_d[DEPTH_LOG2] != rd_entry_d[DEPTH_LOG2]) &&
                 (wr_ptr_d[DEPTH_LOG2-1:0] == rd_entry_d[DEPTH_LOG2-1:0]);
    afull_d    = (level_d >= AFULL_LVL);
    ovf_d      = ovf_q | (bus.wr_valid & ~wr_ready);
    empty_d    = (level_d == '0) && (cnt_d == '0) && (vld_pipe_d == '0);
  end

  // In-flight valid and slice-index shift register matching RAM latency.
  always_comb begin
    vld_pipe_d  = '0;
    sidx_pipe_d = sidx_pipe_q;
    if (!flush) begin
      vld_pipe_d[0]  = issue;
      sidx_pipe_d[0] = cur_sidx;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe_d[i]  = vld_pipe_q[i-1];
        sidx_pipe_d[i] = sidx_pipe_q[i-1];
      end
    end
  end

  // Skid buffer: returned slices enter at tail, head drives rd_data.
  always_comb begin
    skid_d = skid_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        skid_d[tail_q] = ram_slice;
        tail_d         = skid_inc(tail_q);
      end
      if (pop) head_d = skid_inc(head_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + SKID_CW'(1);
        2'b01:   cnt_d = cnt_q - SKID_CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers, asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      vld_pipe_q  <= '0;
      sidx_pipe_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < SKID_N; i++) skid_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
      vld_pipe_q  <= vld_pipe_d;
      sidx_pipe_q <= sidx_pipe_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      skid_q      <= skid_d;
    end
  end

  // last_slice marks the issue that frees an entry; the level drop itself
  // falls out of the rd_ptr entry bits advancing.
  logic unused_ok;
  assign unused_ok = last_slice;

endmodule

// File: tb/tb_multibuffer_stream_queue.sv
// Directed bench for multibuffer_stream_queue: a vector table for the
// single-word latency case, then hand sequences with a slice scoreboard.
module tb_multibuffer_stream_queue;
  localparam int IW = 128, OW = 32, DL = 4, AFM = 4, LAT = 2;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [DL:0]   level;
  logic          empty, almost_full, overflow;

  multibuffer_stream_queue_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  multibuffer_stream_queue #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH_LOG2(DL),
    .AFULL_MARGIN(AFM), .RAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .level(level), .empty(empty), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wv;
    logic [127:0] wd;
    logic         rr;
    logic         fl;
    logic         x_wrdy;
    logic         x_rv;
    logic [31:0]  x_rd;
    logic [4:0]   x_lvl;
    logic         x_emp;
    logic         x_af;
    logic         x_ovf;
  } vec_t;

  vec_t        tbl [9];
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_q [$];
  bit          mon_en = 0;
  int          n_rx = 0, n_acc = 0;
  bit          held_v = 0;
  logic [31:0] held_d = '0;

  function automatic logic [127:0] word(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One cycle: observe at the falling edge, then move past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      if (held_v) begin
        chk("hold_valid", 128'(bus.rd_valid), 128'(1));
        chk("hold_data", 128'(bus.rd_data), 128'(held_d));
      end
      if (bus.wr_valid && bus.wr_ready) begin
        n_acc++;
        for (int k = 0; k < 4; k++) exp_q.push_back(bus.wr_data[k*32 +: 32]);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected: got %0h, want no slice", bus.rd_data);
        end else begin
          chk("rx_data", 128'(bus.rd_data), 128'(exp_q.pop_front()));
        end
      end
      held_v = bus.rd_valid && !bus.rd_ready;
      held_d = bus.rd_data;
      if (flush) begin
        exp_q.delete();
        held_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 400) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: %0d slices outstanding, want 0", nm, exp_q.size());
    end
    tick();
    tick();
    chk({nm, "_empty"}, 128'(empty), 128'(1));
    chk({nm, "_rd_valid"}, 128'(bus.rd_valid), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    int guard, rx0;
    rst = 1'b1; flush = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
    chk("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
    chk("rst_rd_data", 128'(bus.rd_data), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_afull", 128'(almost_full), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));

    // Single word, cycle by cycle
    tbl[0] = '{1'b1, 128'h33333333_22222222_11111111_00000000, 1'b1, 1'b0,
               1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22222222, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33333333, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.wr_valid = tbl[i].wv;
      bus.wr_data  = tbl[i].wd;
      bus.rd_ready = tbl[i].rr;
      flush        = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", i), 128'(bus.wr_ready), 128'(tbl[i].x_wrdy));
      chk($sformatf("v%0d_rd_valid", i), 128'(bus.rd_valid), 128'(tbl[i].x_rv));
      chk($sformatf("v%0d_rd_data", i), 128'(bus.rd_data), 128'(tbl[i].x_rd));
      chk($sformatf("v%0d_level", i), 128'(level), 128'(tbl[i].x_lvl));
      chk($sformatf("v%0d_empty", i), 128'(empty), 128'(tbl[i].x_emp));
      chk($sformatf("v%0d_afull", i), 128'(almost_full), 128'(tbl[i].x_af));
      chk($sformatf("v%0d_overflow", i), 128'(overflow), 128'(tbl[i].x_ovf));
      @(posedge clk);
      #1;
    end

    // Fill to full with the consumer stalled, then one more write attempt
    mon_en = 1;
    bus.rd_ready = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(32'h100 + 32'(4 * k));
      chk($sformatf("fill%0d_level", k), 128'(level), 128'(k));
      chk($sformatf("fill%0d_afull", k), 128'(almost_full), 128'(k >= 12));
      chk($sformatf("fill%0d_wr_ready", k), 128'(bus.wr_ready), 128'(k < 16));
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("fill_overflow", 128'(overflow), 128'(1));
    chk("fill_level_hold", 128'(level), 128'(16));
    chk("fill_afull_hold", 128'(almost_full), 128'(1));
    drain("fill_drain");

    // Backpressure: 64 counting words, random consumer stalls
    n_acc = 0; guard = 0; rx0 = n_rx;
    while (n_acc < 64 && guard < 2000) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(32'h1000 + 32'(4 * n_acc));
      bus.rd_ready = 1'($urandom_range(1, 0));
      tick();
      guard++;
    end
    if (n_acc < 64) begin
      n_vec++; n_err++;
      $display("FAIL bp_write_timeout: accepted %0d, want 64", n_acc);
    end
    drain("bp_drain");
    chk("bp_rx_count", 128'(n_rx - rx0), 128'(256));

    // Flush with reads in flight, then a clean word after it
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_data = word(32'h2000); tick();
    bus.wr_data  = word(32'h2004); tick();
    bus.wr_valid = 1'b0;
    repeat (4) tick();
    chk("flush_pre_valid", 128'(bus.rd_valid), 128'(1));
    flush = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_data = word(32'hDEAD0000);
    #1;
    chk("flush_wr_ready", 128'(bus.wr_ready), 128'(0));
    tick();
    flush = 1'b0; bus.wr_valid = 1'b0;
    chk("flush_rd_valid", 128'(bus.rd_valid), 128'(0));
    chk("flush_level", 128'(level), 128'(0));
    chk("flush_empty", 128'(empty), 128'(1));
    rx0 = n_rx;
    bus.wr_valid = 1'b1; bus.wr_data = word(32'h3000); tick();
    drain("flush_drain");
    chk("flush_rx_count", 128'(n_rx - rx0), 128'(4));

    // Wrap: 100 words with concurrent random read and write
    n_acc = 0; guard = 0; rx0 = n_rx;
    while (n_acc < 100 && guard < 3000) begin
      bus.wr_valid = ($urandom_range(3, 0) != 0);
      bus.wr_data  = word(32'h5000 + 32'(4 * n_acc));
      bus.rd_ready = ($urandom_range(3, 0) != 0);
      tick();
      guard++;
    end
    if (n_acc < 100) begin
      n_vec++; n_err++;
      $display("FAIL wrap_write_timeout: accepted %0d, want 100", n_acc);
    end
    drain("wrap_drain");
    chk("wrap_rx_count", 128'(n_rx - rx0), 128'(400));

    // Asynchronous reset in the middle of a burst
    mon_en = 0;
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(32'h7000 + 32'(4 * k));
      @(posedge clk);
      #1;
    end
    chk("burst_active", 128'(bus.rd_valid), 128'(1));
    chk("ovf_sticky", 128'(overflow), 128'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_wr_ready", 128'(bus.wr_ready), 128'(1));
    chk("arst_rd_valid", 128'(bus.rd_valid), 128'(0));
    chk("arst_rd_data", 128'(bus.rd_data), 128'(0));
    chk("arst_level", 128'(level), 128'(0));
    chk("arst_empty", 128'(empty), 128'(1));
    chk("arst_afull", 128'(almost_full), 128'(0));
    chk("arst_overflow", 128'(overflow), 128'(0));
    bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
